cache: RTL and testbench

CACHE -- requirements
Module: cache

---
 rtl/cache.sv | 222 ++++++++++++++++++++++
 tb/tb_cache.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cache.sv
// Direct-mapped write-back cache: port A is a hit-only read/write port, port B reads and
// refills missing lines from a burst RAM, writing back dirty victims first.
module cache #(
  parameter int unsigned ADDRESS_BITWIDTH          = 32,
  parameter int unsigned DATA_BITWIDTH             = 32,
  parameter int unsigned CACHE_LINE_IX_BITWIDTH    = 1,
  parameter int unsigned CACHE_IX_IN_LINE_BITWIDTH = 3,
  parameter int unsigned RAM_DEPTH_BITWIDTH        = 8,
  parameter int unsigned RAM_BURST_DATA_COUNT      = 4,
  parameter int unsigned RAM_BURST_DATA_BITWIDTH   = 64
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [3:0]                           weA,
  input  logic [ADDRESS_BITWIDTH-1:0]          addrA,
  input  logic [DATA_BITWIDTH-1:0]             dinA,
  output logic [DATA_BITWIDTH-1:0]             doutA,
  input  logic [ADDRESS_BITWIDTH-1:0]          addrB,
  output logic [DATA_BITWIDTH-1:0]             doutB,
  output logic                                 rdyB,
  output logic                                 bsyB,
  output logic                                 br_cmd,
  output logic                                 br_cmd_en,
  output logic [RAM_DEPTH_BITWIDTH-1:0]        br_addr,
  output logic [RAM_BURST_DATA_BITWIDTH-1:0]   br_wr_data,
  output logic [RAM_BURST_DATA_BITWIDTH/8-1:0] br_data_mask,
  input  logic [RAM_BURST_DATA_BITWIDTH-1:0]   br_rd_data,
  input  logic                                 br_rd_data_valid,
  input  logic                                 br_busy
);

  localparam int unsigned ByteW    = $clog2(DATA_BITWIDTH / 8);
  localparam int unsigned WordW    = CACHE_IX_IN_LINE_BITWIDTH;
  localparam int unsigned LineW    = CACHE_LINE_IX_BITWIDTH;
  localparam int unsigned OffW     = ByteW + WordW;
  localparam int unsigned TagW     = ADDRESS_BITWIDTH - OffW - LineW;
  localparam int unsigned Lines    = 1 << LineW;
  localparam int unsigned Words    = 1 << WordW;
  localparam int unsigned Wpb      = RAM_BURST_DATA_BITWIDTH / DATA_BITWIDTH;
  localparam int unsigned RamByteW = $clog2(RAM_BURST_DATA_BITWIDTH / 8);
  localparam int unsigned CntW     = (RAM_BURST_DATA_COUNT > 1) ? $clog2(RAM_BURST_DATA_COUNT) : 1;
  localparam logic [CntW-1:0] LastBeat = CntW'(RAM_BURST_DATA_COUNT - 1);

  typedef enum logic [2:0] {StIdle, StWbCmd, StWbData, StRdCmd, StRdWait} state_e;

  state_e                   state_q, state_d;
  logic [TagW-1:0]          tag_q [Lines];
  logic [TagW-1:0]          tag_d [Lines];
  logic [DATA_BITWIDTH-1:0] data_q [Lines][Words];
  logic [DATA_BITWIDTH-1:0] data_d [Lines][Words];
  logic [Lines-1:0]         valid_q, valid_d, dirty_q, dirty_d;
  logic [LineW-1:0]         fill_line_q, fill_line_d;
  logic [TagW-1:0]          fill_tag_q, fill_tag_d;
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic [DATA_BITWIDTH-1:0] douta_q, douta_d, doutb_q, doutb_d;
  logic                     rdyb_q, rdyb_d;

  logic [LineW-1:0] line_a, line_b;
  logic [WordW-1:0] word_a, word_b;
  logic [TagW-1:0]  tag_a, tag_b;
  logic             hit_a, hit_b, wr_a, victim_dirty;
  logic [ADDRESS_BITWIDTH-1:0]        victim_base, fill_base;
  logic [RAM_BURST_DATA_BITWIDTH-1:0] wb_word;
  logic                               unused_bits;

  assign line_a = addrA[OffW +: LineW];
  assign word_a = addrA[ByteW +: WordW];
  assign tag_a  = addrA[ADDRESS_BITWIDTH-1 -: TagW];
  assign line_b = addrB[OffW +: LineW];
  assign word_b = addrB[ByteW +: WordW];
  assign tag_b  = addrB[ADDRESS_BITWIDTH-1 -: TagW];

  assign hit_a = valid_q[line_a] && (tag_q[line_a] == tag_a);
  assign hit_b = valid_q[line_b] && (tag_q[line_b] == tag_b);
  assign wr_a  = (state_q == StIdle) && hit_a && (weA != 4'b0);
  // A same-cycle port A write makes the victim dirty even if its flag is still clear.
  assign victim_dirty = valid_q[line_b] &&
                        (dirty_q[line_b] || (wr_a && (line_a == line_b)));

  assign victim_base = {tag_q[fill_line_q], fill_line_q, {OffW{1'b0}}};
  assign fill_base   = {fill_tag_q, fill_line_q, {OffW{1'b0}}};
  assign unused_bits = ^{addrA[ByteW-1:0], addrB[ByteW-1:0], victim_base, fill_base};

  always_comb begin
    wb_word = '0;
    for (int unsigned j = 0; j < Wpb; j++) begin
      wb_word[j*DATA_BITWIDTH +: DATA_BITWIDTH] =
        data_q[fill_line_q][WordW'(32'(cnt_q) * Wpb + j)];
    end
  end

  always_comb begin
    br_cmd       = 1'b0;
    br_cmd_en    = 1'b0;
    br_addr      = '0;
    br_wr_data   = '0;
    br_data_mask = '0;
    case (state_q)
      StWbCmd: begin
        br_wr_data = wb_word;
        if (!br_busy) begin
          br_cmd_en = 1'b1;
          br_cmd    = 1'b1;
          br_addr   = victim_base[RamByteW +: RAM_DEPTH_BITWIDTH];
        end
      end
      StWbData: br_wr_data = wb_word;
      StRdCmd: begin
        if (!br_busy) begin
          br_cmd_en = 1'b1;
          br_addr   = fill_base[RamByteW +: RAM_DEPTH_BITWIDTH];
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    tag_d       = tag_q;
    data_d      = data_q;
    valid_d     = valid_q;
    dirty_d     = dirty_q;
    fill_line_d = fill_line_q;
    fill_tag_d  = fill_tag_q;
    cnt_d       = cnt_q;
    doutb_d     = doutb_q;
    rdyb_d      = rdyb_q;
    douta_d     = hit_a ? data_q[line_a][word_a] : '0;

    if (wr_a) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (weA[b]) data_d[line_a][word_a][b*8 +: 8] = dinA[b*8 +: 8];
      end
      dirty_d[line_a] = 1'b1;
    end

    case (state_q)
      StIdle: begin
        if (hit_b) begin
          doutb_d = data_q[line_b][word_b];
          rdyb_d  = 1'b1;
        end else begin
          rdyb_d          = 1'b0;
          valid_d[line_b] = 1'b0;
          fill_line_d     = line_b;
          fill_tag_d      = tag_b;
          cnt_d           = '0;
          state_d         = victim_dirty ? StWbCmd : StRdCmd;
        end
      end
      StWbCmd: begin
        if (!br_busy) begin
          cnt_d   = CntW'(1);
          state_d = StWbData;
        end
      end
      StWbData: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastBeat) state_d = StRdCmd;
      end
      StRdCmd: begin
        if (!br_busy) begin
          cnt_d   = '0;
          state_d = StRdWait;
        end
      end
      StRdWait: begin
        if (br_rd_data_valid) begin
          for (int unsigned j = 0; j < Wpb; j++) begin
            data_d[fill_line_q][WordW'(32'(cnt_q) * Wpb + j)] =
              br_rd_data[j*DATA_BITWIDTH +: DATA_BITWIDTH];
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LastBeat) begin
            tag_d[fill_line_q]   = fill_tag_q;
            valid_d[fill_line_q] = 1'b1;
            dirty_d[fill_line_q] = 1'b0;
            state_d              = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      valid_q     <= '0;
      dirty_q     <= '0;
      fill_line_q <= '0;
      fill_tag_q  <= '0;
      cnt_q       <= '0;
      douta_q     <= '0;
      doutb_q     <= '0;
      rdyb_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
      fill_line_q <= fill_line_d;
      fill_tag_q  <= fill_tag_d;
      cnt_q       <= cnt_d;
      douta_q     <= douta_d;
      doutb_q     <= doutb_d;
      rdyb_q      <= rdyb_d;
    end
  end

  // Line storage carries no reset; the valid bits guard it.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assign doutA = douta_q;
  assign doutB = doutb_q;
  assign rdyB  = rdyb_q;
  assign bsyB  = (state_q != StIdle);

endmodule

// File: tb/tb_cache.sv
// Directed bench for cache with a burst RAM model (read latency 3, 4 beats per burst).
module tb_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  weA;
  logic [31:0] addrA, dinA, doutA, addrB, doutB;
  logic        rdyB, bsyB, br_cmd, br_cmd_en;
  logic [7:0]  br_addr, br_data_mask;
  logic [63:0] br_wr_data, br_rd_data;
  logic        br_rd_data_valid, br_busy;

  int n_tests = 0;
  int n_fail  = 0;

  cache dut (
    .clk              (clk),
    .rst              (rst),
    .weA              (weA),
    .addrA            (addrA),
    .dinA             (dinA),
    .doutA            (doutA),
    .addrB            (addrB),
    .doutB            (doutB),
    .rdyB             (rdyB),
    .bsyB             (bsyB),
    .br_cmd           (br_cmd),
    .br_cmd_en        (br_cmd_en),
    .br_addr          (br_addr),
    .br_wr_data       (br_wr_data),
    .br_data_mask     (br_data_mask),
    .br_rd_data       (br_rd_data),
    .br_rd_data_valid (br_rd_data_valid),
    .br_busy          (br_busy)
  );

  always #5 clk = ~clk;

  // RAM model
  logic [63:0] ram [256];
  logic        loaded = 1'b0;
  logic [7:0]  wr_addr, rd_addr;
  int          wr_left = 0, rd_left = 0, rd_timer = 0;
  int          n_rd = 0, n_wr = 0, busy_viol = 0;

  always @(posedge clk) begin
    if (rst) begin
      if (!loaded) begin
        for (int i = 0; i < 256; i++) ram[i] <= 64'h0;
        ram[0] <= 64'h0403_0201_B7C6_A980;
        ram[1] <= 64'h0000_0000_AB4C_3E6F;
        ram[4] <= 64'h0000_0000_2F5E_3C7A;
        ram[8] <= 64'h0000_0000_4E5F_6A7B;
        loaded <= 1'b1;
      end
      wr_left          <= 0;
      rd_left          <= 0;
      br_rd_data_valid <= 1'b0;
      br_rd_data       <= 64'h0;
    end else begin
      if (br_cmd_en) begin
        if (br_busy) busy_viol <= busy_viol + 1;
        if (br_cmd) begin
          ram[br_addr] <= br_wr_data;
          wr_addr      <= br_addr + 8'd1;
          wr_left      <= 3;
          n_wr         <= n_wr + 1;
        end else begin
          rd_addr  <= br_addr;
          rd_timer <= 3;
          rd_left  <= 4;
          n_rd     <= n_rd + 1;
        end
      end else if (wr_left > 0) begin
        ram[wr_addr] <= br_wr_data & ~{{8{br_data_mask[7]}}, {8{br_data_mask[6]}},
                        {8{br_data_mask[5]}}, {8{br_data_mask[4]}}, {8{br_data_mask[3]}},
                        {8{br_data_mask[2]}}, {8{br_data_mask[1]}}, {8{br_data_mask[0]}}};
        wr_addr <= wr_addr + 8'd1;
        wr_left <= wr_left - 1;
      end
      if (rd_left > 0 && !br_cmd_en) begin
        if (rd_timer > 0) begin
          rd_timer         <= rd_timer - 1;
          br_rd_data_valid <= 1'b0;
        end else begin
          br_rd_data_valid <= 1'b1;
          br_rd_data       <= ram[rd_addr];
          rd_addr          <= rd_addr + 8'd1;
          rd_left          <= rd_left - 1;
        end
      end else begin
        br_rd_data_valid <= 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_rdy(input string tag);
    int n = 0;
    while (!rdyB && n < 100) begin
      step();
      n++;
    end
    chk(tag, 64'(n < 100), 64'd1);
  endtask

  initial begin
    rst = 1'b1; weA = 4'h0; addrA = 32'h0; dinA = 32'h0; addrB = 32'h0; br_busy = 1'b0;
    step();
    step();
    chk("rst_douta", 64'(doutA), 64'h0);
    chk("rst_doutb", 64'(doutB), 64'h0);
    chk("rst_rdyb", 64'(rdyB), 64'h0);
    chk("rst_bsyb", 64'(bsyB), 64'h0);
    chk("rst_cmd_en", 64'(br_cmd_en), 64'h0);
    chk("rst_br_addr", 64'(br_addr), 64'h0);
    chk("rst_wr_data", br_wr_data, 64'h0);

    // Cold miss on address 0
    rst = 1'b0;
    step();
    chk("cold_bsy", 64'(bsyB), 64'h1);
    chk("cold_rdy", 64'(rdyB), 64'h0);
    chk("cold_cmd_en", 64'(br_cmd_en), 64'h1);
    chk("cold_cmd", 64'(br_cmd), 64'h0);
    chk("cold_addr", 64'(br_addr), 64'h0);
    wait_rdy("cold_timeout");
    chk("cold_doutb", 64'(doutB), 64'hB7C6_A980);
    chk("cold_bsy_done", 64'(bsyB), 64'h0);
    chk("cold_nrd", 64'(n_rd), 64'd1);

    // Back-to-back hits
    addrB = 32'd4;
    step();
    chk("hit4_rdy", 64'(rdyB), 64'h1);
    chk("hit4_doutb", 64'(doutB), 64'h0403_0201);
    addrB = 32'd8;
    step();
    chk("hit8_rdy", 64'(rdyB), 64'h1);
    chk("hit8_bsy", 64'(bsyB), 64'h0);
    chk("hit8_doutb", 64'(doutB), 64'hAB4C_3E6F);
    chk("hit_no_cmd", 64'(n_rd + n_wr), 64'd1);

    // Port A hit and miss reads
    addrA = 32'd8;
    step();
    chk("a_hit", 64'(doutA), 64'hAB4C_3E6F);
    addrA = 32'd32;
    step();
    chk("a_miss", 64'(doutA), 64'h0);

    // Clean conflict miss
    addrB = 32'd64;
    step();
    chk("conf_bsy", 64'(bsyB), 64'h1);
    chk("conf_cmd", 64'(br_cmd), 64'h0);
    chk("conf_addr", 64'(br_addr), 64'd8);
    wait_rdy("conf_timeout");
    chk("conf_doutb", 64'(doutB), 64'h4E5F_6A7B);
    chk("conf_nwr", 64'(n_wr), 64'd0);

    // Second line
    addrB = 32'd32;
    step();
    chk("line1_addr", 64'(br_addr), 64'd4);
    wait_rdy("line1_timeout");
    chk("line1_doutb", 64'(doutB), 64'h2F5E_3C7A);
    chk("line1_nrd", 64'(n_rd), 64'd3);

    // Port A write with same-cycle port B read of that word
    addrA = 32'd64; dinA = 32'h1122_3344; weA = 4'hF; addrB = 32'd64;
    step();
    weA = 4'h0;
    chk("prec_old", 64'(doutB), 64'h4E5F_6A7B);
    step();
    chk("prec_new", 64'(doutB), 64'h1122_3344);

    // Dirty eviction
    addrB = 32'd0;
    step();
    chk("wb_cmd_en", 64'(br_cmd_en), 64'h1);
    chk("wb_cmd", 64'(br_cmd), 64'h1);
    chk("wb_addr", 64'(br_addr), 64'd8);
    chk("wb_data0", br_wr_data, 64'h0000_0000_1122_3344);
    chk("wb_mask", 64'(br_data_mask), 64'h0);
    wait_rdy("wb_timeout");
    chk("wb_doutb", 64'(doutB), 64'hB7C6_A980);
    chk("wb_nwr", 64'(n_wr), 64'd1);
    chk("wb_ram", ram[8], 64'h0000_0000_1122_3344);

    // Read-back with RAM busy holding off the command
    br_busy = 1'b1; addrB = 32'd64;
    step();
    chk("busy_bsy", 64'(bsyB), 64'h1);
    chk("busy_hold", 64'(br_cmd_en), 64'h0);
    step();
    chk("busy_hold2", 64'(br_cmd_en), 64'h0);
    br_busy = 1'b0;
    #1;
    chk("busy_release", 64'(br_cmd_en), 64'h1);
    wait_rdy("rb_timeout");
    chk("rb_doutb", 64'(doutB), 64'h1122_3344);

    // Reset in the middle of a fill
    addrB = 32'd96;
    step();
    step();
    step();
    step();
    chk("mid_bsy", 64'(bsyB), 64'h1);
    rst = 1'b1;
    step();
    chk("mid_bsy_rst", 64'(bsyB), 64'h0);
    chk("mid_rdy_rst", 64'(rdyB), 64'h0);
    chk("mid_doutb_rst", 64'(doutB), 64'h0);
    chk("mid_cmd_en_rst", 64'(br_cmd_en), 64'h0);
    rst = 1'b0; addrB = 32'd0;
    step();
    chk("post_rst_miss", 64'(bsyB), 64'h1);
    wait_rdy("post_rst_timeout");
    chk("post_rst_doutb", 64'(doutB), 64'hB7C6_A980);
    chk("no_cmd_while_busy", 64'(busy_viol), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
